// File: rtl/bullet_pkg.sv
// Shared types and helpers for the bullet pool: direction encoding, reversal,
// index-width sizing and default playfield limits.
package bullet_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int X_MAX_DEF = 159;
    localparam int Y_MAX_DEF = 119;

    // Opposite directions differ only in bit 1 (0<->2, 1<->3).
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: position/direction registers, tick movement and boundary
// despawn. Define BULLET_BOUNCE_EN to reverse once at the first boundary hit.
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MAX = Y_MAX_DEF,
    parameter int STEP  = 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           clear,
    input  logic           kill,
    input  logic           tick,
    input  logic           load,
    input  logic [X_W-1:0] load_x,
    input  logic [Y_W-1:0] load_y,
    input  logic [1:0]     load_d,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [1:0]     d,
    output logic           active
);

    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic           out_of_bounds;

`ifdef BULLET_BOUNCE_EN
    logic bounced;
`endif

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        nx            = x;
        ny            = y;
        out_of_bounds = 1'b0;
        case (dir_t'(d))
            DIR_UP:
                if (y < Y_W'(STEP)) out_of_bounds = 1'b1;
                else                ny = y - Y_W'(STEP);
            DIR_DOWN:
                if ({1'b0, y} + (Y_W+1)'(STEP) > (Y_W+1)'(Y_MAX)) out_of_bounds = 1'b1;
                else                                                ny = y + Y_W'(STEP);
            DIR_RIGHT:
                if ({1'b0, x} + (X_W+1)'(STEP) > (X_W+1)'(X_MAX)) out_of_bounds = 1'b1;
                else                                                nx = x + X_W'(STEP);
            default:
                if (x < X_W'(STEP)) out_of_bounds = 1'b1;
                else                nx = x - X_W'(STEP);
        endcase
    end

    // Kill/clear beat movement, movement beats a load; loads only target idle slots.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x      <= '0;
            y      <= '0;
            d      <= '0;
            active <= 1'b0;
`ifdef BULLET_BOUNCE_EN
            bounced <= 1'b0;
`endif
        end else if (clear || kill) begin
            active <= 1'b0;
        end else if (active && tick) begin
            if (!out_of_bounds) begin
                x <= nx;
                y <= ny;
            end else begin
`ifdef BULLET_BOUNCE_EN
                if (!bounced) begin
                    d       <= reverse_dir(dir_t'(d));
                    bounced <= 1'b1;
                end else begin
                    active <= 1'b0;
                end
`else
                active <= 1'b0;
`endif
            end
        end else if (load) begin
            x      <= load_x;
            y      <= load_y;
            d      <= load_d;
            active <= 1'b1;
`ifdef BULLET_BOUNCE_EN
            bounced <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/bullet_array.sv
// Pool of NUM_TANKS x SLOTS bullets: fire edge detect, per-tank cooldown, tick
// divider, kill decode and a registered read port. Bounce: BULLET_BOUNCE_EN.
module bullet_array
    import bullet_pkg::*;
#(
    parameter int NUM_TANKS = 4,
    parameter int SLOTS     = 2,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int X_MAX     = X_MAX_DEF,
    parameter int Y_MAX     = Y_MAX_DEF,
    parameter int TICK_DIV  = 1000000,
    parameter int STEP      = 1,
    parameter int COOLDOWN  = 8,
    parameter int SPAWN_OFF = 3
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   start,
    input  logic [NUM_TANKS-1:0]                   fire,
    input  logic [NUM_TANKS*X_W-1:0]               tx,
    input  logic [NUM_TANKS*Y_W-1:0]               ty,
    input  logic [NUM_TANKS*2-1:0]                 td,
    input  logic                                   kill_valid,
    input  logic [idx_w(NUM_TANKS*SLOTS)-1:0]      kill_id,
    input  logic [idx_w(NUM_TANKS*SLOTS)-1:0]      rd_idx,
    output logic [X_W-1:0]                         rd_x,
    output logic [Y_W-1:0]                         rd_y,
    output logic [1:0]                             rd_d,
    output logic                                   rd_active,
    output logic [NUM_TANKS*SLOTS-1:0]             active,
    output logic [NUM_TANKS-1:0]                   fired,
    output logic                                   tick
);

    localparam int NUM_SLOTS = NUM_TANKS * SLOTS;
    localparam int ID_W      = idx_w(NUM_SLOTS);
    localparam int CNT_W     = idx_w(TICK_DIV);
    localparam int CD_W      = idx_w(COOLDOWN + 1);

    logic [CNT_W-1:0]     tick_cnt;
    logic [NUM_TANKS-1:0] fire_q;
    logic [NUM_TANKS-1:0] fire_rise;
    logic [NUM_TANKS-1:0] alloc;
    logic [CD_W-1:0]      cooldown [NUM_TANKS];
    logic [NUM_SLOTS-1:0] load_vec;
    logic [NUM_SLOTS-1:0] kill_vec;

    logic [X_W-1:0]       slot_x [NUM_SLOTS];
    logic [Y_W-1:0]       slot_y [NUM_SLOTS];
    logic [1:0]           slot_d [NUM_SLOTS];

    logic [X_W-1:0]       rd_x_nx;
    logic [Y_W-1:0]       rd_y_nx;
    logic [1:0]           rd_d_nx;
    logic                 rd_active_nx;

    assign fire_rise = fire & ~fire_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == CNT_W'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            tick     <= 1'b0;
        end
    end

    // Allocation sees the pre-edge active mask, so a slot killed this cycle is not reused yet.
    always_comb begin
        alloc    = '0;
        load_vec = '0;
        for (int t = 0; t < NUM_TANKS; t++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (fire_rise[t] && start && cooldown[t] == '0 && !alloc[t]
                    && !active[t*SLOTS + s]) begin
                    alloc[t]             = 1'b1;
                    load_vec[t*SLOTS + s] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        kill_vec = '0;
        for (int k = 0; k < NUM_SLOTS; k++)
            kill_vec[k] = kill_valid && (kill_id == ID_W'(k));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fire_q <= '0;
            fired  <= '0;
            for (int t = 0; t < NUM_TANKS; t++) cooldown[t] <= '0;
        end else begin
            fire_q <= fire;
            fired  <= alloc;
            for (int t = 0; t < NUM_TANKS; t++) begin
                if (!start)                         cooldown[t] <= '0;
                else if (alloc[t])                  cooldown[t] <= CD_W'(COOLDOWN);
                else if (tick && cooldown[t] != '0) cooldown[t] <= cooldown[t] - 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        localparam int T = k / SLOTS;
        bullet_slot #(
            .X_W   (X_W),
            .Y_W   (Y_W),
            .X_MAX (X_MAX),
            .Y_MAX (Y_MAX),
            .STEP  (STEP)
        ) u_slot (
            .clk    (clk),
            .resetn (resetn),
            .clear  (!start),
            .kill   (kill_vec[k]),
            .tick   (tick),
            .load   (load_vec[k]),
            .load_x (tx[T*X_W +: X_W] + X_W'(SPAWN_OFF)),
            .load_y (ty[T*Y_W +: Y_W] + Y_W'(SPAWN_OFF)),
            .load_d (td[T*2 +: 2]),
            .x      (slot_x[k]),
            .y      (slot_y[k]),
            .d      (slot_d[k]),
            .active (active[k])
        );
    end

    // An index with no matching slot reads back as an idle all-zero slot.
    always_comb begin
        rd_x_nx      = '0;
        rd_y_nx      = '0;
        rd_d_nx      = '0;
        rd_active_nx = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (rd_idx == ID_W'(k)) begin
                rd_x_nx      = slot_x[k];
                rd_y_nx      = slot_y[k];
                rd_d_nx      = slot_d[k];
                rd_active_nx = active[k];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_x      <= '0;
            rd_y      <= '0;
            rd_d      <= '0;
            rd_active <= 1'b0;
        end else begin
            rd_x      <= rd_x_nx;
            rd_y      <= rd_y_nx;
            rd_d      <= rd_d_nx;
            rd_active <= rd_active_nx;
        end
    end

endmodule

// File: tb/tb_bullet_array.sv
// Directed bench for bullet_array with a short tick period; checks spawn,
// movement, cooldown, kill priority, boundary (both BULLET_BOUNCE_EN builds), start and reset.
module tb_bullet_array;

    localparam int TB_DIV = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [3:0]  fire;
    logic [31:0] tx;
    logic [27:0] ty;
    logic [7:0]  td;
    logic        kill_valid;
    logic [2:0]  kill_id;
    logic [2:0]  rd_idx;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic [1:0]  rd_d;
    logic        rd_active;
    logic [7:0]  active;
    logic [3:0]  fired;
    logic        tick;

    int checks = 0;
    int errors = 0;

    bullet_array #(.TICK_DIV(TB_DIV)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .fire       (fire),
        .tx         (tx),
        .ty         (ty),
        .td         (td),
        .kill_valid (kill_valid),
        .kill_id    (kill_id),
        .rd_idx     (rd_idx),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_d       (rd_d),
        .rd_active  (rd_active),
        .active     (active),
        .fired      (fired),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tank;
        int x;
        int y;
        int d;
        int slot;
        int ex;
        int ey;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Stops at a negedge where tick is high: the next posedge processes it.
    task automatic wait_tick_pending();
        int n = 0;
        while (tick !== 1'b1 && n < 2 * TB_DIV) begin
            cyc();
            n++;
        end
        if (tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no tick within %0d cycles", 2 * TB_DIV);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            wait_tick_pending();
            cyc();
        end
    endtask

    task automatic set_tank(input int t, input int x, input int y, input int d);
        tx[t*8 +: 8] = 8'(x);
        ty[t*7 +: 7] = 7'(y);
        td[t*2 +: 2] = 2'(d);
    endtask

    task automatic read_slot(input int idx);
        rd_idx = 3'(idx);
        cyc();
    endtask

    initial begin
        int n;
        int pulses;

        resetn = 1'b0; start = 1'b0; fire = '0; tx = '0; ty = '0; td = '0;
        kill_valid = 1'b0; kill_id = '0; rd_idx = '0;
        vecs[0] = '{0, 10, 20, 0, 0, 13, 23};
        vecs[1] = '{1, 21, 1, 2, 2, 24, 4};
        vecs[2] = '{2, 100, 50, 1, 4, 103, 53};
        vecs[3] = '{3, 0, 0, 3, 6, 3, 3};

        cyc(); cyc();
        check("reset_active", active, 0);
        check("reset_fired", fired, 0);
        check("reset_tick", tick, 0);
        check("reset_rd", {rd_x, rd_y, rd_d, rd_active}, 0);
        resetn = 1'b1;

        n = 0;
        while (tick !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        check("tick_period", n, TB_DIV);
        cyc();
        check("tick_width", tick, 0);

        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_tank(vecs[i].tank, vecs[i].x, vecs[i].y, vecs[i].d);
            fire[vecs[i].tank] = 1'b1;
            cyc();
            check("spawn_fired", fired, 32'(1) << vecs[i].tank);
            check("spawn_active", active[vecs[i].slot], 1);
            fire[vecs[i].tank] = 1'b0;
            rd_idx = 3'(vecs[i].slot);
            cyc();
            check("spawn_fired_clear", fired, 0);
            check("spawn_rd_x", rd_x, vecs[i].ex);
            check("spawn_rd_y", rd_y, vecs[i].ey);
            check("spawn_rd_d", rd_d, vecs[i].d);
            check("spawn_rd_active", rd_active, 1);
        end
        check("spawn_mask", active, 8'h55);

        wait_ticks(5);
        read_slot(2);
        check("move_down_y", rd_y, 9);
        check("move_down_x", rd_x, 24);
        check("move_down_active", rd_active, 1);
        read_slot(6);
`ifdef BULLET_BOUNCE_EN
        check("left_bounce_active", rd_active, 1);
        check("left_bounce_d", rd_d, 1);
        check("left_bounce_x", rd_x, 1);
`else
        check("left_despawn_active", rd_active, 0);
        check("left_despawn_x", rd_x, 0);
`endif

        fire[0] = 1'b1; cyc();
        check("cd3_drop_fired", fired, 0);
        check("cd3_drop_slot1", active[1], 0);
        fire[0] = 1'b0; cyc();
        wait_ticks(2);
        fire[0] = 1'b1; cyc();
        check("cd1_drop_fired", fired, 0);
        fire[0] = 1'b0; cyc();
        wait_ticks(1);
        fire[0] = 1'b1; cyc();
        check("cd0_fired", fired, 1);
        check("cd0_slot1", active[1], 1);
        fire[0] = 1'b0; cyc();
        wait_ticks(8);
        fire[0] = 1'b1; cyc();
        check("full_drop_fired", fired, 0);
        check("full_drop_mask", active[1:0], 2'b11);
        fire[0] = 1'b0; cyc();

        kill_valid = 1'b1; kill_id = 3'd1; cyc();
        kill_valid = 1'b0;
        check("kill_slot1", active[1:0], 2'b01);

        wait_tick_pending();
        kill_valid = 1'b1; kill_id = 3'd0; fire[0] = 1'b1;
        cyc();
        check("prio_kill_slot0", active[0], 0);
        check("prio_alloc_slot1", active[1], 1);
        check("prio_fired", fired, 1);
        kill_valid = 1'b0; fire[0] = 1'b0; rd_idx = 3'd1;
        cyc();
        check("prio_no_move_x", rd_x, 13);
        check("prio_no_move_y", rd_y, 23);
        check("prio_no_move_d", rd_d, 0);
        wait_ticks(8);
        fire[0] = 1'b1; cyc();
        check("slot0_reuse_fired", fired, 1);
        check("slot0_reuse_active", active[0], 1);
        fire[0] = 1'b0; cyc();

        wait_ticks(1);
        set_tank(2, 156, 60, 1);
        fire[2] = 1'b1; cyc();
        check("edge_fired", fired, 4);
        check("edge_slot5", active[5], 1);
        fire[2] = 1'b0; rd_idx = 3'd5; cyc();
        check("edge_spawn_x", rd_x, 159);
        check("edge_spawn_y", rd_y, 63);
        wait_ticks(1);
        read_slot(5);
`ifdef BULLET_BOUNCE_EN
        check("right_bounce_active", rd_active, 1);
        check("right_bounce_d", rd_d, 3);
        check("right_bounce_x", rd_x, 159);
        wait_ticks(159);
        read_slot(5);
        check("cross_active", rd_active, 1);
        check("cross_x", rd_x, 0);
        wait_ticks(1);
        read_slot(5);
        check("second_hit_active", rd_active, 0);
        check("second_hit_x", rd_x, 0);
`else
        check("right_despawn_active", rd_active, 0);
        check("right_despawn_x", rd_x, 159);
`endif

        set_tank(3, 50, 50, 0);
        fire[3] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (fired[3]) pulses++;
        end
        check("held_fire_pulses", pulses, 1);
        fire[3] = 1'b0; cyc();

        read_slot(6);
        check("pre_reset_active", rd_active, 1);
        check("pre_reset_x", rd_x, 53);
        resetn = 1'b0;
        #1;
        check("async_reset_active", active, 0);
        check("async_reset_rd", {rd_x, rd_y, rd_d, rd_active}, 0);
        check("async_reset_fired", fired, 0);
        cyc();
        resetn = 1'b1;

        for (int t = 0; t < 4; t++) set_tank(t, 60, 40, 0);
        fire = 4'hF; cyc();
        check("four_live_mask", active, 8'h55);
        check("four_live_fired", fired, 4'hF);
        fire = 4'h0; start = 1'b0; cyc();
        check("stop_clears", active, 0);
        fire = 4'hF; cyc();
        check("stopped_no_fire", fired, 0);
        start = 1'b1; cyc();
        check("no_edge_after_start", fired, 0);
        check("no_edge_after_start_mask", active, 0);
        fire = 4'h0; cyc();
        fire = 4'hF; cyc();
        check("cd_cleared_by_stop", fired, 4'hF);
        fire = 4'h0; cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bullet_array.md
Name: bullet_array

Overview:
- Parametrised successor to the per-tank single-bullet block.
- Manages a pool of NUM_TANKS × SLOTS bullets: fire edge detection, per-tank cooldown, tick-paced movement, boundary despawn, kill requests from collision logic.
- Sits between keyboard/tank outputs and the control/draw blocks.
- Draw scans bullets through an indexed read port with one-cycle latency.

Parameters:
- NUM_TANKS, 4, number of tank channels
- SLOTS, 2, bullets in flight per tank
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- X_MAX, 159, last legal x
- Y_MAX, 119, last legal y
- TICK_DIV, 1000000, clk cycles per movement tick (50 Hz at 50 MHz)
- STEP, 1, pixels moved per tick
- COOLDOWN, 8, ticks between shots of one tank
- SPAWN_OFF, 3, offset added to tank x/y at spawn

Ports:
- clk, in, 1, system clock
- resetn, in, 1, asynchronous active-low reset
- start, in, 1, game running; low clears the pool
- fire, in, NUM_TANKS, level fire request per tank from the keyboard
- tx, in, NUM_TANKS*X_W, flattened tank x positions
- ty, in, NUM_TANKS*Y_W, flattened tank y positions
- td, in, NUM_TANKS*2, tank facing: 0 up, 1 right, 2 down, 3 left
- kill_valid, in, 1, collision logic requests removal
- kill_id, in, clog2(NUM_TANKS*SLOTS), global slot to remove (tank*SLOTS+slot)
- rd_idx, in, clog2(NUM_TANKS*SLOTS), slot to read
- rd_x, out, X_W, registered x of rd_idx
- rd_y, out, Y_W, registered y of rd_idx
- rd_d, out, 2, registered direction of rd_idx
- rd_active, out, 1, registered active flag of rd_idx
- active, out, NUM_TANKS*SLOTS, live active mask
- fired, out, NUM_TANKS, one-cycle pulse when a tank's shot is allocated
- tick, out, 1, one-cycle movement tick pulse

Behaviour:
- Reset (resetn=0, async): all slots inactive; x/y/d = 0; cooldowns 0; tick divider 0; fire history 0; rd_* = 0; fired = 0; tick = 0.
- Tick: counter counts 0..TICK_DIV-1. tick=1 for exactly one cycle when the counter wraps. Counter runs regardless of start.
- Fire: rising edge = fire[i] & ~fire_q[i]. A held key does not auto-repeat.
- Allocation: on a rising edge with start=1, cooldown[i]=0 and at least one free slot of tank i:
  - the lowest-index free slot loads x=tx[i]+SPAWN_OFF, y=ty[i]+SPAWN_OFF, d=td[i], active=1 at the next edge;
  - cooldown[i] loads COOLDOWN;
  - fired[i] pulses for one cycle.
  - Otherwise the edge is dropped, not queued.
- Cooldown: decrements by 1 on each tick while nonzero.
- Movement: on tick, each active slot moves STEP in its direction. If the move would leave 0..X_MAX / 0..Y_MAX (unsigned underflow included), the slot goes inactive and its position holds.
- Kill: kill_valid clears active of kill_id at the next edge. An out-of-range kill_id is ignored.
- Same-cycle priority per slot: kill > move > allocation.
  - Allocation uses the occupancy from before the edge, so a slot freed this cycle cannot be reused until the next cycle.
  - A newly allocated slot does not move on its allocation cycle.
- start=0: synchronously clears all active flags and cooldowns; fire_q still tracks fire. A start 1→0 mid-flight kills every bullet at the next edge.
- Read port: rd_* reflect the slot state at rd_idx sampled at the previous edge (latency 1). An out-of-range rd_idx returns rd_active=0.

Optional Feature:
- BULLET_BOUNCE_EN defined:
  - each slot carries a bounce flag, cleared at spawn;
  - the first boundary hit reverses direction (0↔2, 1↔3), keeps position and sets the flag;
  - the second boundary hit despawns.
- Undefined: the first boundary hit despawns; no bounce flag is stored.

Decomposition:
- Package bullet_pkg:
  - dir_t (2-bit enum DIR_UP/RIGHT/DOWN/LEFT);
  - reverse-direction function;
  - slot index width helper;
  - default X_MAX/Y_MAX constants.
- Sub-module bullet_slot:
  - holds one slot's registers, move/boundary logic and optional bounce;
  - inputs: load, load values, tick, kill, clear.
  - bullet_array instantiates NUM_TANKS*SLOTS copies and owns the allocator, cooldown, tick divider and read mux.

Test Plan:
- Reset mid-flight: 3 bullets active, pulse resetn low for 1 cycle → active=0, rd_* = 0 immediately.
- Fire tank 1 at tx=21, ty=1, td=2 → fired[1] pulses; slot 2 holds (24,4,down). After 5 ticks y=9; rd_idx=2 returns it one cycle later.
- Fire tank 0 twice within COOLDOWN ticks → second edge dropped. After 8 ticks the next edge allocates slot 1. A third shot with both slots live is dropped.
- Bullet at x=159 moving right, tick → despawns (BULLET_BOUNCE_EN off). With BULLET_BOUNCE_EN on → direction becomes 3, x=159; next hit on the left edge at x=0 despawns.
- kill_valid with kill_id=0 on the same cycle as a tick and a new fire from tank 0 → slot 0 inactive; the new bullet goes to slot 1; slot 0 is reusable next cycle.
- Hold fire high for 100 cycles → only one fired pulse. Drop start while 4 bullets are live → active=0 at the next edge.
